// File: rtl/noise_synth.sv
// ----------------------------------------------------------------------------
// noise_synth
//
// Multi-voice LFSR noise/tone generator with per-voice volume and a
// registered digital mixer, programmed over a narrow 6-bit write bus.
//
// Each voice owns a clock divider, a 10-bit LFSR with a 4-bit tap mask and a
// 4-bit volume. The divider produces a tick every div+1 cycles. Each tick
// advances the LFSR by one step. The voice emits its volume whenever lfsr[0]
// is set. All voice outputs are summed into a registered mix sample.
//
// Optional feature (compile-time macro NOISE_SYNTH_PDM_EN):
//   A first-order sigma-delta modulator converts mix_out into a 1-bit
//   bitstream on pdm_out. Without the macro, pdm_out is constant 0 and no
//   accumulator exists.
//
// Parameters:
//   NUM_VOICES  number of voices, 1..16
//   DIV_WIDTH   divider width per voice, 7..12
//   MIX_W       derived, 4 + clog2(NUM_VOICES), width of the mix sample
//
// Ports:
//   clk      in   1      sole clock, rising edge
//   rst      in   1      synchronous active-high reset
//   wr       in   1      write strobe; the bus is sampled only when wr=1
//   sel      in   1      0 = load address register, 1 = write data
//   din      in   6      address or data value
//   mix_out  out  MIX_W  registered sum of all voice outputs
//   pdm_out  out  1      sigma-delta bitstream (0 when compiled out)
//
// Register map (addr[5:2] = voice index, addr[1:0] = register):
//   0  div[5:0]            <- din[5:0]
//   1  div[DIV_WIDTH-1:6]  <- din[DIV_WIDTH-7:0]
//   2  mask[3:0]           <- din[3:0], also retriggers (lfsr=1, cnt=0)
//   3  vol[3:0]            <- din[3:0]
// ----------------------------------------------------------------------------
module noise_synth #(
   parameter int NUM_VOICES = 4,
   parameter int DIV_WIDTH  = 12,
   localparam int MIX_W     = 4 + $clog2(NUM_VOICES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             sel,
   input  logic [5:0]       din,
   output logic [MIX_W-1:0] mix_out,
   output logic             pdm_out
);

   localparam logic [1:0] REG_DIV_LO = 2'd0;
   localparam logic [1:0] REG_DIV_HI = 2'd1;
   localparam logic [1:0] REG_MASK   = 2'd2;
   localparam logic [1:0] REG_VOL    = 2'd3;

   // -------------------------------------------------------------------------
   // Bus front end
   // -------------------------------------------------------------------------
   logic [5:0] addr_reg;
   logic       addr_wr;
   logic       data_wr;
   logic [3:0] voice_sel;
   logic [1:0] reg_sel;

   assign addr_wr   = wr & ~sel;
   assign data_wr   = wr &  sel;
   assign voice_sel = addr_reg[5:2];
   assign reg_sel   = addr_reg[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg <= '0;
      end else if (addr_wr) begin
         addr_reg <= din;
      end
   end

   // Per-voice output levels, packed so the mixer can iterate over them.
   logic [NUM_VOICES-1:0][3:0] vo_all;

   // -------------------------------------------------------------------------
   // Voices
   // -------------------------------------------------------------------------
   // Voice indices at or above NUM_VOICES never match any gi below, so data
   // writes addressed to them fall through without touching any state.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi = gi + 1) begin : gen_voice
         logic [DIV_WIDTH-1:0] div_reg;
         logic [DIV_WIDTH-1:0] cnt_reg;
         logic [DIV_WIDTH-1:0] cnt_next;
         logic [3:0]           mask_reg;
         logic [3:0]           vol_reg;
         logic [9:0]           lfsr_reg;
         logic [9:0]           lfsr_next;
         logic                 hit;
         logic                 wr_div_lo;
         logic                 wr_div_hi;
         logic                 wr_mask;
         logic                 wr_vol;
         logic                 tick;
         logic                 fb;

         assign hit       = data_wr && (voice_sel == 4'(gi));
         assign wr_div_lo = hit && (reg_sel == REG_DIV_LO);
         assign wr_div_hi = hit && (reg_sel == REG_DIV_HI);
         assign wr_mask   = hit && (reg_sel == REG_MASK);
         assign wr_vol    = hit && (reg_sel == REG_VOL);

         // Compare against the current (pre-write) div, so a div write that
         // lands on a tick only takes effect from the following cycle. A cnt
         // already above a freshly lowered div simply ticks at once.
         assign tick     = (cnt_reg >= div_reg);
         assign cnt_next = tick ? '0 : cnt_reg + DIV_WIDTH'(1);

         assign fb = (lfsr_reg[1] & mask_reg[0]) ^
                     (lfsr_reg[4] & mask_reg[1]) ^
                     (lfsr_reg[6] & mask_reg[2]) ^
                     (lfsr_reg[9] & mask_reg[3]);

         // The all-zero state is only reachable with sparse masks (e.g. the
         // walking one with mask=0); recover to 1 so the voice keeps cycling.
         assign lfsr_next = (lfsr_reg == 10'd0) ? 10'd1 : {lfsr_reg[8:0], fb};

         always_ff @(posedge clk) begin
            if (rst) begin
               div_reg <= '0;
            end else if (wr_div_lo) begin
               div_reg[5:0] <= din;
            end else if (wr_div_hi) begin
               div_reg[DIV_WIDTH-1:6] <= din[DIV_WIDTH-7:0];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               vol_reg <= '0;
            end else if (wr_vol) begin
               vol_reg <= din[3:0];
            end
         end

         // Retrigger outranks a coincident tick: the voice restarts cleanly
         // from lfsr=1 with a fresh divider phase.
         always_ff @(posedge clk) begin
            if (rst) begin
               mask_reg <= '0;
               lfsr_reg <= 10'd1;
               cnt_reg  <= '0;
            end else if (wr_mask) begin
               mask_reg <= din[3:0];
               lfsr_reg <= 10'd1;
               cnt_reg  <= '0;
            end else begin
               cnt_reg <= cnt_next;
               if (tick) begin
                  lfsr_reg <= lfsr_next;
               end
            end
         end

         assign vo_all[gi] = lfsr_reg[0] ? vol_reg : 4'd0;
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Mixer
   // -------------------------------------------------------------------------
   // MIX_W is sized so 15*NUM_VOICES always fits; no saturation is needed.
   logic [MIX_W-1:0] mix_next;
   logic [MIX_W-1:0] mix_reg;

   always_comb begin
      mix_next = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         mix_next = mix_next + MIX_W'(vo_all[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mix_reg <= '0;
      end else begin
         mix_reg <= mix_next;
      end
   end

   assign mix_out = mix_reg;

   // -------------------------------------------------------------------------
   // Sigma-delta output
   // -------------------------------------------------------------------------
`ifdef NOISE_SYNTH_PDM_EN
   // The carry out of a MIX_W-bit phase accumulator fed with mix_out yields
   // a ones density of mix_out / 2^MIX_W. It works from the registered mix,
   // so pdm_out trails mix_out by one cycle.
   logic [MIX_W-1:0] acc_reg;
   logic [MIX_W:0]   acc_sum;
   logic             pdm_reg;

   assign acc_sum = {1'b0, acc_reg} + {1'b0, mix_reg};

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg <= '0;
         pdm_reg <= 1'b0;
      end else begin
         acc_reg <= acc_sum[MIX_W-1:0];
         pdm_reg <= acc_sum[MIX_W];
      end
   end

   assign pdm_out = pdm_reg;
`else
   assign pdm_out = 1'b0;
`endif

endmodule
